// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int DIV_N     = 8;
    localparam int DIV_CNT_W = $clog2(DIV_N + 1);

    // Iteration counter must hold the value n itself, hence n+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_restoring_seq_sub_nb.sv
// Combinational ripple subtractor a - b formed as a + ~b + 1; borrow is the inverted carry-out.
module sub_nb #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic carry;

    assign {carry, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
    assign borrow_o        = ~carry;

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: one quotient bit per cycle behind a start/ready/valid handshake.
// Define DIV_SIGNED_EN for two's-complement operands, with a sign fix-up around the unsigned core.
module div_restoring_seq
    import div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         ready,
    output logic         valid,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(n);

    div_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [n-1:0]  r_q, q_q, d_q;
    logic [n-1:0]  r_d, q_d;
    logic [n-1:0]  dvd_mag, dvs_mag, quo_fin, rem_fin;
    logic [n:0]    trial_diff;
    logic          trial_borrow;
    logic          unused_trial_msb;

    // Trial subtraction of the divisor from the shifted partial remainder.
    sub_nb #(.W(n + 1)) u_trial (
        .a_i      ({r_q, q_q[n-1]}),
        .b_i      ({1'b0, d_q}),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    assign unused_trial_msb = trial_diff[n];

    always_comb begin
        r_d = trial_borrow ? {r_q[n-2:0], q_q[n-1]} : trial_diff[n-1:0];
        q_d = {q_q[n-2:0], ~trial_borrow};
    end

`ifdef DIV_SIGNED_EN
    logic         neg_quo_q, neg_rem_q;
    logic [n-1:0] dvd_neg, dvs_neg, quo_neg, rem_neg;
    logic [3:0]   unused_neg_borrow;

    sub_nb #(.W(n)) u_neg_dvd (.a_i('0), .b_i(dividend), .diff_o(dvd_neg), .borrow_o(unused_neg_borrow[0]));
    sub_nb #(.W(n)) u_neg_dvs (.a_i('0), .b_i(divisor),  .diff_o(dvs_neg), .borrow_o(unused_neg_borrow[1]));
    sub_nb #(.W(n)) u_neg_quo (.a_i('0), .b_i(q_d),      .diff_o(quo_neg), .borrow_o(unused_neg_borrow[2]));
    sub_nb #(.W(n)) u_neg_rem (.a_i('0), .b_i(r_d),      .diff_o(rem_neg), .borrow_o(unused_neg_borrow[3]));

    // MIN/-1 needs no special case: |MIN| negated wraps back to MIN.
    assign dvd_mag = dividend[n-1] ? dvd_neg : dividend;
    assign dvs_mag = divisor[n-1]  ? dvs_neg : divisor;
    assign quo_fin = neg_quo_q ? quo_neg : q_d;
    assign rem_fin = neg_rem_q ? rem_neg : r_d;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign quo_fin = q_d;
    assign rem_fin = r_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            ready       <= 1'b1;
            valid       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            valid       <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            r_q         <= '0;
                            q_q         <= dvd_mag;
                            d_q         <= dvs_mag;
                            cnt_q       <= CW'(n);
                            div_by_zero <= 1'b0;
                            state_q     <= RUN;
`ifdef DIV_SIGNED_EN
                            neg_quo_q   <= dividend[n-1] ^ divisor[n-1];
                            neg_rem_q   <= dividend[n-1];
`endif
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quotient  <= quo_fin;
                        remainder <= rem_fin;
                        valid     <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    ready   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
